// File: rtl/mm_job_scheduler.sv
// Job queue and launch sequencer for the matrix-multiply controller.
// Descriptors are buffered in a FIFO and launched one at a time over the start/valid handshake.
module mm_job_scheduler #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_m_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_k_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_n_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_a_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_b_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_p_i,
  input  logic                    flush_i,
  output logic                    mm_start_o,
  input  logic                    mm_valid_i,
  output logic [ADDR_WIDTH-1:0]   mm_m_o,
  output logic [ADDR_WIDTH-1:0]   mm_k_o,
  output logic [ADDR_WIDTH-1:0]   mm_n_o,
  output logic [ADDR_WIDTH-1:0]   mm_base_a_o,
  output logic [ADDR_WIDTH-1:0]   mm_base_b_o,
  output logic [ADDR_WIDTH-1:0]   mm_base_p_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic [CNT_WIDTH-1:0]    done_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned DW = 6 * ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DW-1:0]         r_cfg;
  logic                  r_start;
  logic                  r_done;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_done_cnt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_hs;
  logic                  w_zero;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_finish;
  logic [DW-1:0]         w_din;

  assign w_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  // Gated by rst_ni so every output reads 0 while reset is held.
  assign cmd_ready_o = rst_ni && !w_full && !flush_i;
  assign w_hs        = cmd_valid_i && cmd_ready_o;
  assign w_zero      = (cmd_m_i == '0) || (cmd_k_i == '0) || (cmd_n_i == '0);
  assign w_push      = w_hs && !w_zero;
  assign w_din       = {cmd_m_i, cmd_k_i, cmd_n_i, cmd_base_a_i, cmd_base_b_i, cmd_base_p_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty && !flush_i) begin
          w_pop       = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (mm_valid_i) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!mm_valid_i) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_din;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Start is high exactly while the FSM sits in RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg      <= '0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_pop) r_cfg <= r_mem[r_rd_ptr];
      r_start <= (w_state_nxt == RUN);
      r_done  <= w_finish;
      r_err   <= w_hs && w_zero;
      if (w_finish) r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
    end
  end

  assign {mm_m_o, mm_k_o, mm_n_o, mm_base_a_o, mm_base_b_o, mm_base_p_o} = r_cfg;
  assign mm_start_o = r_start;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign level_o    = r_level;
  assign done_cnt_o = r_done_cnt;

endmodule
